ps2_keyboard_matrix: RTL and testbench
======================================

# ps2_keyboard_matrix

Upstream keyboard front-end for the `c64` top. It receives PS/2 set-2 scancodes and keeps a 64-key C64 matrix state. It answers the CIA1 row scan by driving `keyboard_COL` from the `keyboard_ROW` pattern the top exports. The C64 has no dedicated key-matrix pin for RESTORE, so that key comes out on a separate line the top ORs into NMI.

## Interface
Parameters:
- `FILTER_LEN`, default 8: consecutive identical `clk` samples required before a PS/2 clock level change is accepted.
- `TIMEOUT`, default 16384: idle `clk` cycles inside a frame before the frame is aborted.

Ports:
- `clk`, in, 1: system clock; the top connects `dot_clk`.
- `reset`, in, 1: synchronous, active-high.
- `ps2_clk`, in, 1: asynchronous PS/2 clock, device-driven.
- `ps2_data`, in, 1: asynchronous PS/2 data.
- `keyboard_ROW`, in, 8: CIA1 PA output; a 0 selects a row.
- `keyboard_COL`, out, 8: to CIA1 PB input; a 0 means a pressed key in some selected row.
- `restore`, out, 1: high while RESTORE (PS/2 PageUp, E0 7D) is held.
- `rx_error`, out, 1: one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
- **Input conditioning:** `ps2_clk` and `ps2_data` each pass a 2-FF synchronizer. Filtered clock takes a new level only after `FILTER_LEN` equal samples. A falling edge of the filtered clock is a bit strobe.
- **Receiver states:**
  - IDLE: a strobe with data 0 moves to DATA; a strobe with data 1 is ignored.
  - DATA: 8 strobes, LSB first.
  - PARITY: 1 strobe. Odd parity is required; a mismatch is flagged but the state still advances.
  - STOP: 1 strobe. Data must be 1. If parity and stop are good, a byte is emitted for 1 cycle; otherwise `rx_error` pulses. Either way the state returns to IDLE.
  - Timeout: in any non-IDLE state, `TIMEOUT` cycles without a strobe cause IDLE plus an `rx_error` pulse. The bit count is cleared.
- **Decoder:**
  - Byte E0 sets `ext`; byte F0 sets `brk`. Neither changes the matrix.
  - Any other byte is looked up with {`ext`, code} as the key. A hit gives (row, col). The result is set to `!brk` at `matrix[row*8+col]`, then `ext` and `brk` clear.
  - A byte with no map entry only clears `ext` and `brk`.
  - E0 7D sets `restore` to `!brk` and does not touch the matrix.
  - E1 (Pause) and its sequence bytes are unmapped and therefore ignored.
- **Mandatory map entries** (row = PA bit, col = PB bit):
  - 5A RETURN = (0,1); 66 DEL = (0,0); 05 F1 = (0,4).
  - 1C A = (1,2); 1B S = (1,5); 1D W = (1,1); 12 LSHIFT = (1,7).
  - 59 RSHIFT = (6,4); 29 SPACE = (7,4); 14 CTRL = (7,2); 16 1 = (7,0).
  - The remaining C64 keys are mapped positionally.
- **Column output:** `keyboard_COL[c]` = NOT(OR over r of (`!keyboard_ROW[r]` AND `matrix[r*8+c]`)). Ghosting is not modelled.
- **Reset values:** matrix all 0; `keyboard_COL` = FF; `restore` = 0; `rx_error` = 0; `ext` = `brk` = 0; receiver in IDLE.
- A reset in mid-frame discards the partial byte. Once the synchronizers settle, the next start bit is accepted.

## Timing
- `keyboard_COL` is registered. It reflects `keyboard_ROW` and the matrix as of the previous `clk` edge, giving 1-cycle latency. This is far below one CIA access.
- The matrix bit updates on the cycle after the byte-valid pulse, so `keyboard_COL` changes 2 cycles after the stop strobe.
- Filtering adds a delay of `FILTER_LEN`+2 cycles from a pin edge to its strobe.
- If a byte-valid pulse and a timeout fall on the same cycle, the byte is taken and no error is raised; the receiver is already in IDLE.
- A repeated make code (typematic repeat) rewrites 1 and is harmless. A break code for a key that is not pressed writes 0, which is also harmless.

## Structure
- Shared package `c64_kbd_pkg`:
  - receiver state enum;
  - constants `PS2_EXT` = E0, `PS2_BRK` = F0, `PS2_RESTORE` = 7D;
  - the scancode-to-(row,col) map as a function returning {valid, row[2:0], col[2:0]}.
- Sub-module `ps2_rx` holds the synchronizers, filter, frame FSM and timeout. It outputs `byte[7:0]`, `byte_valid` and `rx_error`.
- The top-level file holds the prefix decoder, matrix and column logic.

## Test plan
- Send frame 1C with good parity, then hold `keyboard_ROW` = FD. Required: `keyboard_COL` = FB. With `keyboard_ROW` = FF, required: `keyboard_COL` = FF.
- Send 1C then F0 1C. Required: `keyboard_COL` = FF at `keyboard_ROW` = 00 after the break code.
- Hold LSHIFT (12) and SPACE (29) with `keyboard_ROW` = 00. Required: `keyboard_COL` = 6F (bits 7 and 4 low).
- Send 1C with bad parity. Required: one `rx_error` pulse and the matrix unchanged. A following good frame 5A gives `keyboard_COL` = FD at `keyboard_ROW` = FE.
- Stop `ps2_clk` after 4 data bits for more than `TIMEOUT` cycles. Required: `rx_error` pulses and the next full frame 29 decodes correctly.
- Send E0 7D. Required: `restore` = 1. Then send E0 F0 7D. Required: `restore` = 0, and `keyboard_COL` = FF at `keyboard_ROW` = 00 throughout. Assert `reset` mid-frame. Required: all outputs return to their reset values.

Source files
------------

// File: rtl/c64_kbd_pkg.sv
// Shared definitions for the PS/2-to-C64 keyboard front-end: receiver states,
// prefix byte constants and the set-2 scancode to C64 matrix position map.
package c64_kbd_pkg;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] PS2_EXT     = 8'hE0;
  localparam logic [7:0] PS2_BRK     = 8'hF0;
  localparam logic [7:0] PS2_RESTORE = 8'h7D;

  function automatic logic [6:0] km(input logic [2:0] row, input logic [2:0] col);
    return {1'b1, row, col};
  endfunction

  // Returns {valid, row, col}; row is the CIA PA bit, col the CIA PB bit.
  // Keys without a set-2 twin are placed on the PC key in the same position.
  function automatic logic [6:0] kbd_map(input logic ext, input logic [7:0] code);
    logic [6:0] m;
    m = 7'd0;
    case ({ext, code})
      9'h066: m = km(3'd0, 3'd0); 9'h05A: m = km(3'd0, 3'd1);
      9'h174: m = km(3'd0, 3'd2); 9'h083: m = km(3'd0, 3'd3);
      9'h005: m = km(3'd0, 3'd4); 9'h004: m = km(3'd0, 3'd5);
      9'h003: m = km(3'd0, 3'd6); 9'h172: m = km(3'd0, 3'd7);
      9'h026: m = km(3'd1, 3'd0); 9'h01D: m = km(3'd1, 3'd1);
      9'h01C: m = km(3'd1, 3'd2); 9'h025: m = km(3'd1, 3'd3);
      9'h01A: m = km(3'd1, 3'd4); 9'h01B: m = km(3'd1, 3'd5);
      9'h024: m = km(3'd1, 3'd6); 9'h012: m = km(3'd1, 3'd7);
      9'h02E: m = km(3'd2, 3'd0); 9'h02D: m = km(3'd2, 3'd1);
      9'h023: m = km(3'd2, 3'd2); 9'h036: m = km(3'd2, 3'd3);
      9'h021: m = km(3'd2, 3'd4); 9'h02B: m = km(3'd2, 3'd5);
      9'h02C: m = km(3'd2, 3'd6); 9'h022: m = km(3'd2, 3'd7);
      9'h03D: m = km(3'd3, 3'd0); 9'h035: m = km(3'd3, 3'd1);
      9'h034: m = km(3'd3, 3'd2); 9'h03E: m = km(3'd3, 3'd3);
      9'h032: m = km(3'd3, 3'd4); 9'h033: m = km(3'd3, 3'd5);
      9'h03C: m = km(3'd3, 3'd6); 9'h02A: m = km(3'd3, 3'd7);
      9'h046: m = km(3'd4, 3'd0); 9'h043: m = km(3'd4, 3'd1);
      9'h03B: m = km(3'd4, 3'd2); 9'h045: m = km(3'd4, 3'd3);
      9'h03A: m = km(3'd4, 3'd4); 9'h042: m = km(3'd4, 3'd5);
      9'h044: m = km(3'd4, 3'd6); 9'h031: m = km(3'd4, 3'd7);
      9'h04E: m = km(3'd5, 3'd0); 9'h04D: m = km(3'd5, 3'd1);
      9'h04B: m = km(3'd5, 3'd2); 9'h055: m = km(3'd5, 3'd3);
      9'h049: m = km(3'd5, 3'd4); 9'h04C: m = km(3'd5, 3'd5);
      9'h054: m = km(3'd5, 3'd6); 9'h041: m = km(3'd5, 3'd7);
      9'h170: m = km(3'd6, 3'd0); 9'h05B: m = km(3'd6, 3'd1);
      9'h052: m = km(3'd6, 3'd2); 9'h16C: m = km(3'd6, 3'd3);
      9'h059: m = km(3'd6, 3'd4); 9'h05D: m = km(3'd6, 3'd5);
      9'h169: m = km(3'd6, 3'd6); 9'h04A: m = km(3'd6, 3'd7);
      9'h016: m = km(3'd7, 3'd0); 9'h00E: m = km(3'd7, 3'd1);
      9'h014: m = km(3'd7, 3'd2); 9'h01E: m = km(3'd7, 3'd3);
      9'h029: m = km(3'd7, 3'd4); 9'h011: m = km(3'd7, 3'd5);
      9'h015: m = km(3'd7, 3'd6); 9'h076: m = km(3'd7, 3'd7);
      default: m = 7'd0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, clock glitch filter, 11-bit frame
// FSM with odd-parity/stop checking and an inactivity timeout.
module ps2_rx
  import c64_kbd_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 16384
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       rx_error
);

  localparam int CNT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam int TIMER_W = $clog2(TIMEOUT + 1);

  logic [1:0]         clk_sync_reg, data_sync_reg;
  logic               clk_filt_reg;
  logic [CNT_W-1:0]   filt_cnt_reg;
  rx_state_t          state_reg;
  logic [2:0]         bit_cnt_reg;
  logic [7:0]         shift_reg;
  logic               par_err_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic [7:0]         byte_reg;
  logic               valid_reg, error_reg;
  logic               filt_commit, strobe, data_bit;

  assign data_bit    = data_sync_reg[1];
  assign filt_commit = (clk_sync_reg[1] != clk_filt_reg) &&
                       (filt_cnt_reg == CNT_W'(FILTER_LEN - 1));
  // The strobe fires on the cycle the filtered clock commits to low.
  assign strobe      = filt_commit && clk_filt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
      clk_filt_reg  <= 1'b1;
      filt_cnt_reg  <= '0;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2_data};
      if (clk_sync_reg[1] == clk_filt_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_commit) begin
        clk_filt_reg <= clk_sync_reg[1];
        filt_cnt_reg <= '0;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= RX_IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      par_err_reg <= 1'b0;
      timer_reg   <= '0;
      byte_reg    <= '0;
      valid_reg   <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      error_reg <= 1'b0;
      if (strobe) begin
        timer_reg <= '0;
        case (state_reg)
          RX_IDLE: begin
            bit_cnt_reg <= '0;
            if (!data_bit) state_reg <= RX_DATA;
          end
          RX_DATA: begin
            shift_reg   <= {data_bit, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == 3'd7) state_reg <= RX_PARITY;
          end
          RX_PARITY: begin
            par_err_reg <= ~(^{data_bit, shift_reg});
            state_reg   <= RX_STOP;
          end
          RX_STOP: begin
            if (data_bit && !par_err_reg) begin
              byte_reg  <= shift_reg;
              valid_reg <= 1'b1;
            end else begin
              error_reg <= 1'b1;
            end
            state_reg <= RX_IDLE;
          end
          default: state_reg <= RX_IDLE;
        endcase
      end else if (state_reg != RX_IDLE) begin
        if (timer_reg == TIMER_W'(TIMEOUT - 1)) begin
          state_reg   <= RX_IDLE;
          bit_cnt_reg <= '0;
          timer_reg   <= '0;
          error_reg   <= 1'b1;
        end else begin
          timer_reg <= timer_reg + 1'b1;
        end
      end
    end
  end

  assign rx_byte    = byte_reg;
  assign byte_valid = valid_reg;
  assign rx_error   = error_reg;

endmodule

// File: rtl/ps2_keyboard_matrix.sv
// PS/2 keyboard to C64 key matrix: prefix decoder, 64-bit key state and the
// registered CIA1 column response; RESTORE is reported on its own line.
module ps2_keyboard_matrix
  import c64_kbd_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 16384
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] keyboard_ROW,
  output logic [7:0] keyboard_COL,
  output logic       restore,
  output logic       rx_error
);

  logic [7:0]  rx_byte;
  logic        byte_valid;
  logic        ext_reg, brk_reg, restore_reg;
  logic [63:0] matrix_reg;
  logic [7:0]  col_reg, col_next;
  logic [6:0]  map_hit;

  ps2_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .rx_error  (rx_error)
  );

  assign map_hit = kbd_map(ext_reg, rx_byte);

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_reg     <= 1'b0;
      brk_reg     <= 1'b0;
      restore_reg <= 1'b0;
      matrix_reg  <= '0;
    end else if (byte_valid) begin
      if (rx_byte == PS2_EXT) begin
        ext_reg <= 1'b1;
      end else if (rx_byte == PS2_BRK) begin
        brk_reg <= 1'b1;
      end else begin
        // RESTORE has no matrix position; it drives the NMI line instead.
        if (ext_reg && rx_byte == PS2_RESTORE) restore_reg <= !brk_reg;
        else if (map_hit[6]) matrix_reg[map_hit[5:0]] <= !brk_reg;
        ext_reg <= 1'b0;
        brk_reg <= 1'b0;
      end
    end
  end

  genvar gi, gr;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_col
      logic [7:0] col_keys;
      for (gr = 0; gr < 8; gr++) begin : g_row
        assign col_keys[gr] = matrix_reg[gr*8 + gi];
      end
      assign col_next[gi] = ~|(col_keys & ~keyboard_ROW);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) col_reg <= 8'hFF;
    else       col_reg <= col_next;
  end

  assign keyboard_COL = col_reg;
  assign restore      = restore_reg;

endmodule

// File: tb/tb_ps2_keyboard_matrix.sv
// Scoreboard bench: stimulus queues expected column/restore values and error
// pulses; independent monitors pop and compare when the DUT responds.
module tb_ps2_keyboard_matrix;

  localparam int FL   = 4;
  localparam int TO   = 1000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keyboard_ROW = 8'hFF;
  logic [7:0] keyboard_COL;
  logic       restore;
  logic       rx_error;

  ps2_keyboard_matrix #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .keyboard_ROW(keyboard_ROW),
    .keyboard_COL(keyboard_COL),
    .restore     (restore),
    .rx_error    (rx_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] row;
    logic [7:0] col;
    logic       rst;
    int         id;
  } exp_t;

  exp_t chk_q[$];
  int   err_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_busy = 1'b0;
  int   check_id = 0;

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(!bad_stop);
    ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((chk_q.size() != 0 || mon_busy) && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL monitor_timeout: got pending=%0d required pending=0", chk_q.size());
    end
  endtask

  task automatic check(input logic [7:0] row, input logic [7:0] col, input logic rs);
    @(negedge clk);
    keyboard_ROW = row;
    check_id++;
    chk_q.push_back('{row, col, rs, check_id});
    wait_idle();
  endtask

  // Column/restore monitor: response is due two cycles after the row is applied.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_q.size() > 0) begin
        e = chk_q.pop_front();
        mon_busy = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (keyboard_COL !== e.col) begin
          n_fail++;
          $display("FAIL check%0d keyboard_COL at ROW=%h: got %h required %h", e.id, e.row, keyboard_COL, e.col);
        end
        n_checks++;
        if (restore !== e.rst) begin
          n_fail++;
          $display("FAIL check%0d restore: got %b required %b", e.id, restore, e.rst);
        end
        $display("check%0d ROW=%h COL=%h restore=%b", e.id, e.row, keyboard_COL, restore);
        mon_busy = 1'b0;
      end
    end
  end

  // Error monitor: every rx_error pulse must match a queued expectation.
  always @(negedge clk) begin
    if (!reset && rx_error === 1'b1) begin
      n_checks++;
      if (err_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rx_error: got 1 required 0");
      end else begin
        $display("rx_error pulse for case %0d", err_q.pop_front());
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (5) @(posedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    check(8'h00, 8'hFF, 1'b0);

    // A press and release
    send(8'h1C);
    check(8'hFD, 8'hFB, 1'b0);
    check(8'hFF, 8'hFF, 1'b0);
    check(8'h00, 8'hFB, 1'b0);
    send(8'hF0); send(8'h1C);
    check(8'h00, 8'hFF, 1'b0);

    // LSHIFT + SPACE
    send(8'h12); send(8'h29);
    check(8'h00, 8'h6F, 1'b0);
    check(8'hFD, 8'h7F, 1'b0);
    check(8'h7F, 8'hEF, 1'b0);
    send(8'hF0); send(8'h12);
    send(8'hF0); send(8'h29);
    check(8'h00, 8'hFF, 1'b0);

    // Extended prefix: plain 74 unmapped, E0 74 is cursor right (0,2)
    send(8'h74);
    check(8'h00, 8'hFF, 1'b0);
    send(8'hE0); send(8'h74);
    check(8'hFE, 8'hFB, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h74);
    check(8'h00, 8'hFF, 1'b0);

    // Bad parity, then a good RETURN
    err_q.push_back(1);
    send_frame(8'h1C, 1'b1, 1'b0);
    check(8'h00, 8'hFF, 1'b0);
    send(8'h5A);
    check(8'hFE, 8'hFD, 1'b0);
    check(8'h00, 8'hFD, 1'b0);

    // Bad stop bit: W must not register
    err_q.push_back(2);
    send_frame(8'h1D, 1'b0, 1'b1);
    check(8'hFD, 8'hFF, 1'b0);

    // Timeout after 4 data bits, then SPACE
    err_q.push_back(3);
    ps2_bit(1'b0);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (TO + 200) @(posedge clk);
    send(8'h29);
    check(8'h7F, 8'hEF, 1'b0);
    check(8'h00, 8'hED, 1'b0);
    send(8'hF0); send(8'h5A);
    send(8'hF0); send(8'h29);
    check(8'h00, 8'hFF, 1'b0);

    // RESTORE
    send(8'hE0); send(8'h7D);
    check(8'h00, 8'hFF, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h7D);
    check(8'h00, 8'hFF, 1'b0);

    // Reset in mid-frame
    send(8'h1C);
    send(8'hE0); send(8'h7D);
    check(8'h00, 8'hFB, 1'b1);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    ps2_data = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check(8'h00, 8'hFF, 1'b0);
    repeat (20) @(posedge clk);
    send(8'h1B);
    check(8'hFD, 8'hDF, 1'b0);

    // Typematic repeat and break of an unpressed key
    send(8'h1B);
    send(8'hF0); send(8'h1D);
    check(8'hFD, 8'hDF, 1'b0);

    repeat (50) @(posedge clk);
    n_checks++;
    if (err_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_rx_error: got %0d pulses short required 0", err_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
